// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the multi-port register file.
package reg_file_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  localparam int RF_DATA_W_DEF   = 8;
  localparam int RF_NUM_REGS_DEF = 16;

endpackage

// File: rtl/reg_file_read_port.sv
// One registered read port: range check, storage mux, write-first bypass.
// REGFILE_ZERO_REG_EN forces reads of register 0 to zero, bypass included.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W_DEF,
  parameter int NUM_REGS = RF_NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_i,
  input  logic              wr_fire_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic [DATA_W-1:0] mem_i [NUM_REGS],
  output logic [DATA_W-1:0] dout_o
);

  logic              in_range_s;
  logic [DATA_W-1:0] dout_d;
  logic [DATA_W-1:0] dout_q;

  // Select next output word; wr_fire_i already implies an in-range write address.
  always_comb begin
    in_range_s = (int'(raddr_i) < NUM_REGS);
    dout_d     = {DATA_W{1'b0}};
    if (!run_i) begin
      dout_d = {DATA_W{1'b0}};
    end else if (!in_range_s) begin
      dout_d = {DATA_W{1'b0}};
`ifdef REGFILE_ZERO_REG_EN
    end else if (raddr_i == {ADDR_W{1'b0}}) begin
      dout_d = {DATA_W{1'b0}};
`endif
    end else if (wr_fire_i && (waddr_i == raddr_i)) begin
      dout_d = wdata_i;
    end else begin
      dout_d = mem_i[raddr_i];
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= {DATA_W{1'b0}};
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/reg_file_mp.sv
// 1W/2R register file with self-clearing reset sequence and write-first bypass.
// Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter  int DATA_W   = RF_DATA_W_DEF,
  parameter  int NUM_REGS = RF_NUM_REGS_DEF,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] dout_a,
  output logic [DATA_W-1:0] dout_b,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic              run_s;
  logic              wr_fire_s;

  // Clear sequencer: walk every entry once, then open the file.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ready_d   = ready_q;
    case (state_q)
      RF_CLEAR: begin
        if (clr_ptr_q == LAST_IDX) begin
          state_d   = RF_RUN;
          ready_d   = 1'b1;
          clr_ptr_d = {ADDR_W{1'b0}};
        end else begin
          clr_ptr_d = clr_ptr_q + ADDR_W'(1'b1);
        end
      end
      RF_RUN: begin
        state_d = RF_RUN;
      end
      default: begin
        state_d   = RF_CLEAR;
        clr_ptr_d = {ADDR_W{1'b0}};
        ready_d   = 1'b0;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RF_CLEAR;
      clr_ptr_q <= {ADDR_W{1'b0}};
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
    end
  end

  // Write qualification: only in RUN, only to existing (and writable) registers.
  always_comb begin
    run_s     = (state_q == RF_RUN);
    wr_fire_s = run_s && write_en && (int'(waddr) < NUM_REGS);
`ifdef REGFILE_ZERO_REG_EN
    if (waddr == {ADDR_W{1'b0}}) begin
      wr_fire_s = 1'b0;
    end else begin
      wr_fire_s = wr_fire_s;
    end
`endif
  end

  // Storage; left untouched on the reset edge itself.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == RF_CLEAR) begin
        mem_q[clr_ptr_q] <= {DATA_W{1'b0}};
      end else if (wr_fire_s) begin
        mem_q[waddr] <= wdata;
      end
    end
  end

  reg_file_read_port #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W)
  ) u_rd_a (
    .clk      (clk),
    .rst      (rst),
    .run_i    (run_s),
    .wr_fire_i(wr_fire_s),
    .waddr_i  (waddr),
    .wdata_i  (wdata),
    .raddr_i  (raddr_a),
    .mem_i    (mem_q),
    .dout_o   (dout_a)
  );

  reg_file_read_port #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W)
  ) u_rd_b (
    .clk      (clk),
    .rst      (rst),
    .run_i    (run_s),
    .wr_fire_i(wr_fire_s),
    .waddr_i  (waddr),
    .wdata_i  (wdata),
    .raddr_i  (raddr_b),
    .mem_i    (mem_q),
    .dout_o   (dout_b)
  );

  assign ready = ready_q;

endmodule
